// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: pipelined multiply with MUL_LAT-cycle latency,
// and a 32-iteration radix-2 restoring divider. Both can be cancelled by the flush path.
module muldiv_unit #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        isbusy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // state | meaning
  // IDLE  | no operation in flight; MTHI/MTLO writes allowed
  // MUL   | multiply latency countdown
  // DIV   | restoring divide, one quotient bit per cycle
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] a_q, b_q, rem;
  logic        mul_signed, neg_q, neg_r, div_zero;
  logic        accept, done, mt_ok;

  logic        mul_sgn;
  logic [31:0] mul_a, mul_b;
  logic [63:0] ma, mb, prod;

  logic [32:0] rem_sh, diff;
  logic        q_bit;
  logic [31:0] rem_nx, quo_nx, hi_fin, lo_fin;

  assign accept = (state == IDLE) && start && !cancel && !rst;
  assign isbusy = accept || (state != IDLE);
  assign mt_ok  = (state == IDLE) && !accept;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op[1])             state_nxt = DIV;
          else if (MUL_LAT > 1)  state_nxt = MUL;
        end
      end
      MUL, DIV: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (cnt == 6'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In IDLE the multiplier sees the live operands so MUL_LAT=1 can finish on the accept edge.
  always_comb begin
    mul_sgn = (state == IDLE) ? ~op[0] : mul_signed;
    mul_a   = (state == IDLE) ? src_a : a_q;
    mul_b   = (state == IDLE) ? src_b : b_q;
    ma      = {{32{mul_sgn & mul_a[31]}}, mul_a};
    mb      = {{32{mul_sgn & mul_b[31]}}, mul_b};
    prod    = ma * mb;
  end

  // a_q doubles as the dividend/quotient shift register during DIV.
  always_comb begin
    rem_sh = {rem, a_q[31]};
    diff   = rem_sh - {1'b0, b_q};
    q_bit  = ~diff[32];
    rem_nx = q_bit ? diff[31:0] : rem_sh[31:0];
    quo_nx = {a_q[30:0], q_bit};
    lo_fin = div_zero ? 32'hFFFF_FFFF : (neg_q ? -quo_nx : quo_nx);
    hi_fin = neg_r ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 6'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      rem        <= 32'd0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mul_signed <= ~op[0];
        if (op[1]) begin
          a_q      <= (~op[0] & src_a[31]) ? -src_a : src_a;
          b_q      <= (~op[0] & src_b[31]) ? -src_b : src_b;
          rem      <= 32'd0;
          neg_q    <= ~op[0] & (src_a[31] ^ src_b[31]);
          neg_r    <= ~op[0] & src_a[31];
          div_zero <= (src_b == 32'd0);
          cnt      <= 6'd31;
        end else begin
          a_q <= src_a;
          b_q <= src_b;
          cnt <= 6'(MUL_LAT > 1 ? MUL_LAT - 2 : 0);
        end
      end else if (state == DIV && !cancel) begin
        a_q <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt - 1'b1;
      end else if (state == MUL && !cancel) begin
        cnt <= cnt - 1'b1;
      end

      if (done) begin
        if (state == MUL) {hi, lo} <= prod;
        else              {hi, lo} <= {hi_fin, lo_fin};
      end else if (accept && !op[1] && MUL_LAT == 1) begin
        {hi, lo} <= prod;
      end else if (mt_ok) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with MUL_LAT=2.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, cancel, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        isbusy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .isbusy(isbusy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    checks++;
    if (isbusy !== 1'b1) begin failures++; $display("FAIL %s busy_c0 got=%b exp=1", nm, isbusy); end
    next_cycle();
    start = 1'b0;
    for (int c = 1; c < lat; c++) begin
      checks++;
      if (isbusy !== 1'b1) begin failures++; $display("FAIL %s busy_c%0d got=%b exp=1", nm, c, isbusy); end
      next_cycle();
    end
    checks++;
    if (isbusy !== 1'b0) begin failures++; $display("FAIL %s busy_done got=%b exp=0", nm, isbusy); end
    checks++;
    if (hi !== ehi) begin failures++; $display("FAIL %s hi got=%h exp=%h", nm, hi, ehi); end
    checks++;
    if (lo !== elo) begin failures++; $display("FAIL %s lo got=%h exp=%h", nm, lo, elo); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (isbusy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", isbusy); end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo); end
  endtask

  task automatic test_mult();
    do_op("mult_neg2x3",  2'b00, 32'hFFFF_FFFE, 32'd3,        2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu_fffex3", 2'b01, 32'hFFFF_FFFE, 32'd3,        2, 32'h0000_0002, 32'hFFFF_FFFA);
    do_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_negneg",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'h0000_0000, 32'h0000_0001);
  endtask

  task automatic test_div();
    do_op("divu_100_7",  2'b11, 32'd100,      32'd7,        33, 32'd2,        32'd14);
    do_op("div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,        32'h8000_0000);
    do_op("div_7_m2",    2'b10, 32'd7,        32'hFFFF_FFFE, 33, 32'd1,        32'hFFFF_FFFD);
    do_op("divu_5_0",    2'b11, 32'd5,        32'd0,        33, 32'd5,        32'hFFFF_FFFF);
    do_op("div_m5_0",    2'b10, 32'hFFFF_FFFB, 32'd0,        33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    do_op("divu_big",    2'b11, 32'hFFFF_FFFF, 32'd16,       33, 32'd15,       32'h0FFF_FFFF);
  endtask

  task automatic test_mt();
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
    next_cycle();
    hi_we = 1'b0;
    wdata = 32'h5A5A_0002;
    next_cycle();
    lo_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_0001) begin failures++; $display("FAIL mt_hi got=%h exp=a5a50001", hi); end
    checks++;
    if (lo !== 32'h5A5A_0002) begin failures++; $display("FAIL mt_lo got=%h exp=5a5a0002", lo); end
    // Write in the start cycle must be dropped; HI checked before the multiply completes.
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    next_cycle();
    start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_0001) begin failures++; $display("FAIL mt_start_drop got=%h exp=a5a50001", hi); end
    next_cycle();
    checks++;
    if (hi !== 32'd0 || lo !== 32'd6) begin failures++; $display("FAIL mt_then_mul got=%h_%h exp=0_6", hi, lo); end
  endtask

  task automatic test_cancel();
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
    next_cycle();
    hi_we = 1'b0; lo_we = 1'b0;
    // cancel in cycle 10
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    next_cycle();
    start = 1'b0;
    repeat (9) next_cycle();
    cancel = 1'b1;
    next_cycle();
    cancel = 1'b0;
    checks++;
    if (isbusy !== 1'b0) begin failures++; $display("FAIL cancel10_busy got=%b exp=0", isbusy); end
    repeat (30) next_cycle();
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222) begin
      failures++; $display("FAIL cancel10_hilo got=%h_%h exp=11112222_11112222", hi, lo);
    end
    // cancel in the completion cycle 32
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    next_cycle();
    start = 1'b0;
    repeat (31) next_cycle();
    checks++;
    if (isbusy !== 1'b1) begin failures++; $display("FAIL cancel32_busy_c32 got=%b exp=1", isbusy); end
    cancel = 1'b1;
    next_cycle();
    cancel = 1'b0;
    checks++;
    if (isbusy !== 1'b0) begin failures++; $display("FAIL cancel32_busy got=%b exp=0", isbusy); end
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222) begin
      failures++; $display("FAIL cancel32_hilo got=%h_%h exp=11112222_11112222", hi, lo);
    end
  endtask

  task automatic test_cancel_with_start();
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5;
    #1;
    checks++;
    if (isbusy !== 1'b0) begin failures++; $display("FAIL cstart_busy_c0 got=%b exp=0", isbusy); end
    next_cycle();
    start = 1'b0; cancel = 1'b0;
    checks++;
    if (isbusy !== 1'b0) begin failures++; $display("FAIL cstart_busy_c1 got=%b exp=0", isbusy); end
    next_cycle();
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222) begin
      failures++; $display("FAIL cstart_hilo got=%h_%h exp=11112222_11112222", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    next_cycle();
    start = 1'b0;
    repeat (4) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    checks++;
    if (isbusy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL rstmid_now got=%b_%h_%h exp=0_0_0", isbusy, hi, lo);
    end
    repeat (40) next_cycle();
    checks++;
    if (isbusy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++; $display("FAIL rstmid_later got=%b_%h_%h exp=0_0_0", isbusy, hi, lo);
    end
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    next_cycle();
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'd0) begin
      failures++; $display("FAIL mthi_idle got=%h_%h exp=00001234_0", hi, lo);
    end
    // MTHI while a divide is running is dropped
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd4;
    next_cycle();
    start = 1'b0;
    repeat (2) next_cycle();
    hi_we = 1'b1; wdata = 32'hCAFE_0000;
    next_cycle();
    hi_we = 1'b0;
    checks++;
    if (hi !== 32'h0000_1234) begin failures++; $display("FAIL mthi_busy got=%h exp=00001234", hi); end
    repeat (29) next_cycle();
    checks++;
    if (isbusy !== 1'b0 || hi !== 32'd1 || lo !== 32'd2) begin
      failures++; $display("FAIL mthi_busy_result got=%b_%h_%h exp=0_1_2", isbusy, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_mult",  2'b00, 32'd6,  32'hFFFF_FFFF, 2,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("b2b_divu",  2'b11, 32'd50, 32'd8,         33, 32'd2,        32'd6);
    do_op("b2b_multu", 2'b01, 32'd7,  32'd9,         2,  32'd0,        32'd63);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_cancel();
    test_cancel_with_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
